// File: rtl/quadtree_local_interface_pkg.sv
// quadtree_local_interface_pkg: router flit field widths, offsets and packing helper.
package quadtree_local_interface_pkg;
  localparam int ROUTER_INFO_WIDTH = 4;
  localparam int ROUTER_ADDR_WIDTH = 8;
  localparam int ROUTER_DATA_WIDTH = 32;
  localparam int ROUTER_WIDTH = ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + ROUTER_DATA_WIDTH;
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB = PAYLOAD_LSB + ROUTER_DATA_WIDTH;
  localparam int INFO_LSB = ADDR_LSB + ROUTER_ADDR_WIDTH;
  typedef logic [ROUTER_WIDTH-1:0] flit_t;
  function automatic flit_t pack_flit(input logic [ROUTER_INFO_WIDTH-1:0] info,
                                      input logic [ROUTER_ADDR_WIDTH-1:0] addr,
                                      input logic [ROUTER_DATA_WIDTH-1:0] payload);
    flit_t f;
    f = '0;
    f[INFO_LSB +: ROUTER_INFO_WIDTH] = info;
    f[ADDR_LSB +: ROUTER_ADDR_WIDTH] = addr;
    f[PAYLOAD_LSB +: ROUTER_DATA_WIDTH] = payload;
    return f;
  endfunction
endpackage

// File: rtl/quadtree_ni_fifo.sv
// quadtree_ni_fifo: synchronous FIFO with wrap-bit pointers; head reads as zero when empty.
module quadtree_ni_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
endmodule

// File: rtl/quadtree_local_interface.sv
// quadtree_local_interface: PE <-> router DIR_LOCAL network interface with credit flow control.
// Define QT_NI_STATS_EN to implement the tx/rx flit statistics counters.
module quadtree_local_interface
  import quadtree_local_interface_pkg::*;
#(
  parameter int CREDIT_NUM = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [ROUTER_INFO_WIDTH-1:0] tx_info,
  input  logic [ROUTER_ADDR_WIDTH-1:0] tx_addr,
  input  logic [ROUTER_DATA_WIDTH-1:0] tx_payload,
  output logic                         inj_valid,
  output logic [ROUTER_WIDTH-1:0]      inj_data,
  input  logic                         inj_credit,
  input  logic                         ej_valid,
  input  logic [ROUTER_WIDTH-1:0]      ej_data,
  output logic                         ej_credit,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [ROUTER_INFO_WIDTH-1:0] rx_info,
  output logic [ROUTER_ADDR_WIDTH-1:0] rx_addr,
  output logic [ROUTER_DATA_WIDTH-1:0] rx_payload,
  output logic                         credit_err,
  output logic                         rx_overflow,
  output logic [15:0]                  tx_flit_cnt,
  output logic [15:0]                  rx_flit_cnt
);
  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_NUM);
  logic [CW-1:0] credit;
  logic send, pop, push, full, empty, over;
  flit_t head;
  assign tx_ready = credit != '0;
  assign send = tx_valid & tx_ready;
  // a surplus credit is rejected rather than wrapping the counter
  assign over = inj_credit & ~send & (credit == CMAX);
  assign push = ej_valid & ~full;
  assign rx_valid = ~empty;
  assign pop = rx_valid & rx_ready;
  assign rx_info = head[INFO_LSB +: ROUTER_INFO_WIDTH];
  assign rx_addr = head[ADDR_LSB +: ROUTER_ADDR_WIDTH];
  assign rx_payload = head[PAYLOAD_LSB +: ROUTER_DATA_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit <= CMAX;
      inj_valid <= 1'b0;
      inj_data <= '0;
      ej_credit <= 1'b0;
      credit_err <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      credit <= over ? credit : credit - CW'(send) + CW'(inj_credit);
      inj_valid <= send;
      if (send) inj_data <= pack_flit(tx_info, tx_addr, tx_payload);
      ej_credit <= pop;
      credit_err <= credit_err | over;
      rx_overflow <= rx_overflow | (ej_valid & full);
    end
  quadtree_ni_fifo #(.DEPTH(RX_DEPTH), .W(ROUTER_WIDTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(ej_data),
    .rdata(head), .full(full), .empty(empty)
  );
`ifdef QT_NI_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_flit_cnt <= '0;
      rx_flit_cnt <= '0;
    end else begin
      tx_flit_cnt <= tx_flit_cnt + 16'(send);
      rx_flit_cnt <= rx_flit_cnt + 16'(pop);
    end
`else
  assign tx_flit_cnt = '0;
  assign rx_flit_cnt = '0;
`endif
endmodule

// File: tb/tb_quadtree_local_interface.sv
// tb_quadtree_local_interface: queue-based reference model plus directed and random stimulus.
module tb_quadtree_local_interface;
  import quadtree_local_interface_pkg::*;
  localparam int CREDIT_NUM = 4;
  localparam int RX_DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic tx_valid = 0, tx_ready, inj_valid, inj_credit = 0, ej_valid = 0, ej_credit;
  logic rx_valid, rx_ready = 0, credit_err, rx_overflow;
  logic [ROUTER_INFO_WIDTH-1:0] tx_info = 0, rx_info;
  logic [ROUTER_ADDR_WIDTH-1:0] tx_addr = 0, rx_addr;
  logic [ROUTER_DATA_WIDTH-1:0] tx_payload = 0, rx_payload;
  logic [ROUTER_WIDTH-1:0] inj_data, ej_data = 0;
  logic [15:0] tx_flit_cnt, rx_flit_cnt;
  int errors = 0, checks = 0;

  quadtree_local_interface #(.CREDIT_NUM(CREDIT_NUM), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_info(tx_info),
    .tx_addr(tx_addr), .tx_payload(tx_payload), .inj_valid(inj_valid), .inj_data(inj_data),
    .inj_credit(inj_credit), .ej_valid(ej_valid), .ej_data(ej_data), .ej_credit(ej_credit),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_info(rx_info), .rx_addr(rx_addr),
    .rx_payload(rx_payload), .credit_err(credit_err), .rx_overflow(rx_overflow),
    .tx_flit_cnt(tx_flit_cnt), .rx_flit_cnt(rx_flit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int m_credit = CREDIT_NUM;
  bit m_inj_valid, m_ej_credit, m_cerr, m_ovf;
  logic [ROUTER_WIDTH-1:0] m_inj_data;
  logic [ROUTER_WIDTH-1:0] q[$];
  logic [15:0] m_tx, m_rx;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_credit = CREDIT_NUM;
      m_inj_valid = 0;
      m_inj_data = '0;
      m_ej_credit = 0;
      m_cerr = 0;
      m_ovf = 0;
      q.delete();
      m_tx = 0;
      m_rx = 0;
    end else begin
      automatic bit snd = tx_valid && m_credit != 0;
      automatic bit pp = rx_ready && q.size() != 0;
      automatic bit was_full = q.size() == RX_DEPTH;
      m_inj_valid = snd;
      if (snd) m_inj_data = {tx_info, tx_addr, tx_payload};
      m_ej_credit = pp;
      if (inj_credit && !snd && m_credit == CREDIT_NUM) m_cerr = 1;
      else m_credit = m_credit - int'(snd) + int'(inj_credit);
      if (pp) void'(q.pop_front());
      if (ej_valid) begin
        if (was_full) m_ovf = 1;
        else q.push_back(ej_data);
      end
      m_tx = m_tx + 16'(snd);
      m_rx = m_rx + 16'(pp);
    end
  end

  always begin
    @(negedge clk);
    chk("tx_ready", tx_ready, m_credit != 0);
    chk("inj_valid", inj_valid, m_inj_valid);
    chk("inj_data", inj_data, m_inj_data);
    chk("ej_credit", ej_credit, m_ej_credit);
    chk("rx_valid", rx_valid, q.size() != 0);
    chk("rx_head", {rx_info, rx_addr, rx_payload}, q.size() != 0 ? q[0] : '0);
    chk("credit_err", credit_err, m_cerr);
    chk("rx_overflow", rx_overflow, m_ovf);
`ifdef QT_NI_STATS_EN
    chk("tx_flit_cnt", tx_flit_cnt, m_tx);
    chk("rx_flit_cnt", rx_flit_cnt, m_rx);
`else
    chk("tx_flit_cnt", tx_flit_cnt, 16'h0);
    chk("rx_flit_cnt", rx_flit_cnt, 16'h0);
`endif
  end

  initial begin
    int n;
    tick(2);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_inj_valid", inj_valid, 0);
    // burst with no credit return: exactly CREDIT_NUM flits
    rst_n = 1;
    tx_valid = 1;
    tx_info = 4'hA;
    tx_addr = 8'h5C;
    tx_payload = 32'h12345678;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) chk("inj_data_pack", inj_data, 44'hA5C12345678);
      if (inj_valid) n++;
    end
    chk("burst_pulses", n, 4);
    chk("burst_tx_ready", tx_ready, 0);
    tx_valid = 0;
    inj_credit = 1;
    tick();
    inj_credit = 0;
    chk("credit_back_ready", tx_ready, 1);
    tx_valid = 1;
    tick();
    tx_valid = 0;
    chk("credit_used", tx_ready, 0);
    inj_credit = 1;
    tick();
    tx_valid = 1;
    tick();
    tx_valid = 0;
    chk("send_and_credit", tx_ready, 1);
    chk("send_and_credit_pulse", inj_valid, 1);
    tick(3);
    chk("no_err_yet", credit_err, 0);
    tick();
    inj_credit = 0;
    chk("credit_err_set", credit_err, 1);
    tick(3);
    chk("credit_err_sticky", credit_err, 1);
    chk("credit_full", tx_ready, 1);
    // fill the ejection FIFO, then overflow it
    for (int i = 0; i < 4; i++) begin
      ej_valid = 1;
      ej_data = {4'(i), 8'(8'h10 + i), 32'(32'hA0 + i)};
      tick();
      if (i == 0) begin
        chk("ej_first_visible", rx_valid, 1);
        chk("ej_first_payload", rx_payload, 32'hA0);
      end
    end
    ej_data = {4'hF, 8'hFF, 32'hEE};
    tick();
    ej_valid = 0;
    chk("overflow_set", rx_overflow, 1);
    rx_ready = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", rx_payload, 32'hA0 + i);
      tick();
      if (ej_credit) n++;
    end
    rx_ready = 0;
    chk("drain_empty", rx_valid, 0);
    chk("drain_credits", n, 4);
    tick();
    chk("drain_credit_done", ej_credit, 0);
    // steady push/pop through pointer wrap
    ej_valid = 1;
    rx_ready = 1;
    for (int i = 0; i < 10; i++) begin
      ej_data = {4'h3, 8'h20, 32'(32'hB0 + i)};
      tick();
    end
    ej_valid = 0;
    rx_ready = 0;
    chk("stream_last", rx_payload, 32'hB9);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    // reset with 2 flits buffered, credit 1, and pulses in flight
    tx_valid = 1;
    ej_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ej_data = {4'h5, 8'h30, 32'(32'hC0 + i)};
      tick();
    end
    tx_valid = 0;
    ej_valid = 0;
    rx_ready = 1;
    tick();
    rx_ready = 0;
    rst_n = 0;
    #1;
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_ej_credit", ej_credit, 0);
    chk("rst_inj_valid", inj_valid, 0);
    chk("rst_inj_data", inj_data, 0);
    chk("rst_overflow", rx_overflow, 0);
    tick();
    rst_n = 1;
    tick(2);
    chk("post_rst_ej_credit", ej_credit, 0);
    chk("post_rst_inj_valid", inj_valid, 0);
    chk("post_rst_rx_valid", rx_valid, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_info = 4'($urandom);
      tx_addr = 8'($urandom);
      tx_payload = $urandom;
      inj_credit = (m_credit < CREDIT_NUM) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
      ej_valid = 1'($urandom_range(0, 1));
      ej_data = {4'($urandom), 8'($urandom), 32'($urandom)};
      rx_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    tx_valid = 0;
    inj_credit = 0;
    ej_valid = 0;
    rx_ready = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
